// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Loads a length-prefixed little-endian word stream into instruction
//            memory, holding the CPU in reset until the load completes.
//            Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter logic [63:0] BASE_ADDRESS = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        write,
  output logic [63:0] output_address,
  output logic [31:0] output_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd4
  } state_t;
`endif

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [1:0]  r_byte;
  logic [23:0] r_buf;
  logic        r_ready;
  logic        r_write;
  logic [63:0] r_addr;
  logic [31:0] r_data;
  logic        r_cpu_reset;
  logic        r_done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_error;
`endif

  logic        w_xfer;
  logic        w_last_word;
  logic [63:0] w_addr;
  logic [15:0] w_len;

  assign w_xfer      = in_valid & r_ready;
  assign w_last_word = (r_index == (r_count - 16'd1));
  assign w_addr      = BASE_ADDRESS + {46'd0, r_index, 2'b00};
  assign w_len       = {r_count[15:8], in_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= LEN_HI;
      r_count     <= 16'd0;
      r_index     <= 16'd0;
      r_byte      <= 2'd0;
      r_buf       <= 24'd0;
      r_ready     <= 1'b1;
      r_write     <= 1'b0;
      r_addr      <= 64'd0;
      r_data      <= 32'd0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum      <= 8'd0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_write <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          LEN_HI: begin
            r_count[15:8] <= in_data;
            r_state       <= LEN_LO;
          end
          LEN_LO: begin
            r_count[7:0] <= in_data;
            if (w_len != 16'd0) begin
              r_state <= DATA;
            end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state     <= DONE;
              r_ready     <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
`endif
            end
          end
          DATA: begin
            // Shift in LSB-first so the 4th byte completes {b3,b2,b1,b0}
            r_buf  <= {in_data, r_buf[23:8]};
            r_byte <= r_byte + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_data;
`endif
            if (r_byte == 2'd3) begin
              r_write <= 1'b1;
              r_data  <= {in_data, r_buf};
              r_addr  <= w_addr;
              r_index <= r_index + 16'd1;
              if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                r_state <= CHECK;
`else
                r_state     <= DONE;
                r_ready     <= 1'b0;
                r_done      <= 1'b1;
                r_cpu_reset <= 1'b0;
`endif
              end
            end
          end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          CHECK: begin
            r_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready       = r_ready;
  assign write          = r_write;
  assign output_address = r_addr;
  assign output_data    = r_data;
  assign cpu_reset      = r_cpu_reset;
  assign done           = r_done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error          = r_error;
`else
  assign error          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Randomized self-checking bench for program_loader (two instances,
//            BASE_ADDRESS 0 and 0x100) against a byte-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam logic [63:0] BASE_B = 64'h100;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy_a, wr_a, cpu_a, done_a, err_a;
  logic [63:0] addr_a;
  logic [31:0] data_a;
  logic        rdy_b, wr_b, cpu_b, done_b, err_b;
  logic [63:0] addr_b;
  logic [31:0] data_b;

  always #5 clock = ~clock;

  program_loader #(.BASE_ADDRESS(64'h0)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .write(wr_a), .output_address(addr_a), .output_data(data_a),
    .cpu_reset(cpu_a), .done(done_a), .error(err_a)
  );

  program_loader #(.BASE_ADDRESS(BASE_B)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .write(wr_b), .output_address(addr_b), .output_data(data_b),
    .cpu_reset(cpu_b), .done(done_b), .error(err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks stream position in bytes and derives outputs from it
  int          m_pos, m_n, m_idx;
  logic [7:0]  m_word [4];
  logic [7:0]  m_xor;
  bit          live = 1'b0;
  logic        e_ready, e_write, e_done, e_error, e_cpu;
  logic [63:0] e_addr_a, e_addr_b;
  logic [31:0] e_data;

  always @(posedge clock) begin
    if (reset) begin
      m_pos = 0; m_n = 0; m_xor = 8'h00;
      e_ready = 1'b1; e_write = 1'b0; e_done = 1'b0; e_error = 1'b0; e_cpu = 1'b1;
      e_addr_a = 64'h0; e_addr_b = 64'h0; e_data = 32'h0;
      live = 1'b1;
    end else if (live) begin
      e_write = 1'b0;
      if (in_valid && e_ready) begin
        if (m_pos == 0) begin
          m_n = int'(in_data) * 256;
        end else if (m_pos == 1) begin
          m_n = m_n + int'(in_data);
          if (m_n == 0 && !CSUM) begin
            e_done = 1'b1; e_cpu = 1'b0; e_ready = 1'b0;
          end
        end else begin
          m_idx = m_pos - 2;
          if (m_idx < 4 * m_n) begin
            m_word[m_idx % 4] = in_data;
            m_xor = m_xor ^ in_data;
            if (m_idx % 4 == 3) begin
              e_write  = 1'b1;
              e_data   = {m_word[3], m_word[2], m_word[1], m_word[0]};
              e_addr_a = 64'(4 * (m_idx / 4));
              e_addr_b = BASE_B + 64'(4 * (m_idx / 4));
              if (m_idx == 4 * m_n - 1 && !CSUM) begin
                e_done = 1'b1; e_cpu = 1'b0; e_ready = 1'b0;
              end
            end
          end else begin
            e_ready = 1'b0;
            if (in_data == m_xor) begin
              e_done = 1'b1; e_cpu = 1'b0;
            end else begin
              e_error = 1'b1;
            end
          end
        end
        m_pos++;
      end
    end
  end

  // Cycle-by-cycle compare plus write monitors used by the literal pins
  int          wr_cnt_a = 0, wr_cnt_b = 0;
  logic [63:0] last_addr_a = 64'h0, last_addr_b = 64'h0;
  logic [31:0] last_data_a = 32'h0;

  always @(negedge clock) begin
    if (live) begin
      chk("ready_a", rdy_a, e_ready);   chk("ready_b", rdy_b, e_ready);
      chk("write_a", wr_a, e_write);    chk("write_b", wr_b, e_write);
      chk("done_a", done_a, e_done);    chk("done_b", done_b, e_done);
      chk("error_a", err_a, e_error);   chk("error_b", err_b, e_error);
      chk("cpurst_a", cpu_a, e_cpu);    chk("cpurst_b", cpu_b, e_cpu);
      chk("addr_a", addr_a, e_addr_a);  chk("addr_b", addr_b, e_addr_b);
      chk("data_a", data_a, e_data);    chk("data_b", data_b, e_data);
      if (wr_a === 1'b1) begin
        wr_cnt_a++; last_addr_a = addr_a; last_data_a = data_a;
      end
      if (wr_b === 1'b1) begin
        wr_cnt_b++; last_addr_b = addr_b;
      end
    end
  end

  logic [7:0] q [$];

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0; in_data = 8'($urandom);
    end
  endtask

  // mode 0: continuous, 1: toggle every other cycle, 2: random gaps
  task automatic send_q(input int mode);
    int gap;
    foreach (q[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
      @(negedge clock);
      in_valid = 1'b1; in_data = q[i];
    end
  endtask

  task automatic push_word(input logic [31:0] w, inout logic [7:0] x);
    for (int k = 0; k < 4; k++) begin
      q.push_back(w[8*k +: 8]);
      x = x ^ w[8*k +: 8];
    end
  endtask

  int         base_a, base_b, n, cut;
  logic [7:0] x;
  logic [31:0] w;

  initial begin
    do_reset();
    chk("reset_ready", rdy_a, 1'b1);
    chk("reset_cpurst", cpu_a, 1'b1);

    // Single-word load
    base_a = wr_cnt_a;
    q = '{8'h00, 8'h01, 8'h13, 8'h00, 8'h00, 8'h91};
    if (CSUM) q.push_back(8'h82);
    send_q(0);
    idle(3);
    chk("one_word_writes", 64'(wr_cnt_a - base_a), 64'd1);
    chk("one_word_addr", last_addr_a, 64'h0);
    chk("one_word_addr_b", last_addr_b, 64'h100);
    chk("one_word_data", 64'(last_data_a), 64'h91000013);
    chk("one_word_done", done_a, 1'b1);
    chk("one_word_cpurst", cpu_a, 1'b0);

    // Bytes offered after completion are refused
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_q(0);
    idle(2);
    chk("after_done_writes", 64'(wr_cnt_a - base_a), 64'd1);
    chk("after_done_data", 64'(data_a), 64'h91000013);
    chk("after_done_ready", rdy_a, 1'b0);

    // Three words, in_valid toggling
    do_reset();
    base_b = wr_cnt_b;
    x = 8'h00;
    q = '{8'h00, 8'h03};
    push_word(32'h11223344, x);
    push_word(32'hA5A55A5A, x);
    push_word(32'hCAFEF00D, x);
    if (CSUM) q.push_back(x);
    send_q(1);
    idle(3);
    chk("three_writes", 64'(wr_cnt_b - base_b), 64'd3);
    chk("three_last_addr", last_addr_b, 64'h108);
    chk("three_last_data", 64'(last_data_a), 64'hCAFEF00D);

    // Empty program
    do_reset();
    base_a = wr_cnt_a;
    q = '{8'h00, 8'h00};
    if (CSUM) q.push_back(8'h00);
    send_q(0);
    @(negedge clock);
    in_valid = 1'b0;
    chk("empty_done", done_a, 1'b1);
    idle(2);
    chk("empty_writes", 64'(wr_cnt_a - base_a), 64'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum
    do_reset();
    q = '{8'h00, 8'h01, 8'h13, 8'h00, 8'h00, 8'h91, 8'hFF};
    send_q(0);
    idle(2);
    q = '{8'h00, 8'h00, 8'h00};
    send_q(0);
    idle(2);
    chk("bad_csum_error", err_a, 1'b1);
    chk("bad_csum_done", done_a, 1'b0);
    chk("bad_csum_cpurst", cpu_a, 1'b1);
    chk("bad_csum_ready", rdy_a, 1'b0);
`endif

    // Reset in the middle of word 1, then a fresh single-word load
    do_reset();
    q = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_q(0);
    do_reset();
    base_a = wr_cnt_a;
    x = 8'h00;
    q = '{8'h00, 8'h01};
    push_word(32'hAABBCCDD, x);
    if (CSUM) q.push_back(x);
    send_q(0);
    idle(3);
    chk("restart_writes", 64'(wr_cnt_a - base_a), 64'd1);
    chk("restart_addr", last_addr_a, 64'h0);
    chk("restart_addr_b", last_addr_b, 64'h100);
    chk("restart_data", 64'(last_data_a), 64'hAABBCCDD);
    chk("restart_done", done_a, 1'b1);

    // Randomized streams: random length, gaps, truncation and checksum errors
    for (int it = 0; it < 40; it++) begin
      do_reset();
      n = int'($urandom_range(0, 6));
      x = 8'h00;
      q = '{8'(n >> 8), 8'(n)};
      for (int j = 0; j < n; j++) begin
        w = $urandom;
        push_word(w, x);
      end
      if (CSUM) q.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
      if ($urandom_range(0, 4) == 0) begin
        cut = int'($urandom_range(0, q.size()));
        while (q.size() > cut) void'(q.pop_back());
      end
      send_q(2);
      idle(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
